db_event_arbiter: RTL and testbench

Debounce-and-arbitration controller for a bank of N mechanical inputs (buttons/switches). Each raw input is synchronized, sampled on a shared slow tick and debounced by a per-channel state machine. Debounced press events (0→1 transitions) are queued as one pending bit per channel and handed out one at a time, round-robin, on a valid/ready event port. The block sits between board-level switch inputs and any consumer FSM that needs exactly one event per physical press.

---
 rtl/db_event_arbiter_pkg.sv | 13 +
 rtl/db_event_arbiter_channel.sv | 111 +++++++++++
 rtl/db_event_arbiter.sv | 104 ++++++++++
 tb/tb_db_event_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/db_event_arbiter_pkg.sv
// Shared types for the switch debounce / event arbiter slice.
package db_event_arbiter_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_LO     = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HI     = 2'd2,
    ST_CHK_LO = 2'd3
  } db_state_e;

endpackage

// File: rtl/db_event_arbiter_channel.sv
// One switch channel: 2-flop synchronizer, tick-sampled debounce FSM and
// a combinational press pulse on the edge that accepts a new high level.
module db_event_arbiter_channel
  import db_event_arbiter_pkg::*;
#(
  parameter int unsigned STABLE = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_in,
  output logic o_level,
  output logic o_press_c
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic [1:0]       r_sync;
  db_state_e        r_state;
  db_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_s;

  assign w_s       = r_sync[1];
  assign w_cnt_inc = r_cnt + ONE_C;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_in};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_LO;
      r_cnt   <= '0;
      o_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      o_level <= (w_state_nxt == ST_HI) || (w_state_nxt == ST_CHK_LO);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_press_c   = 1'b0;
    if (i_tick) begin
      case (r_state)
        ST_LO: begin
          if (w_s) begin
            if (STABLE_C == ONE_C) begin
              w_state_nxt = ST_HI;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_CHK_HI;
              w_cnt_nxt   = ONE_C;
            end
          end
        end
        ST_CHK_HI: begin
          if (!w_s) begin
            w_state_nxt = ST_LO;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == STABLE_C) begin
            w_state_nxt = ST_HI;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_HI: begin
          if (!w_s) begin
            if (STABLE_C == ONE_C) begin
              w_state_nxt = ST_LO;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_CHK_LO;
              w_cnt_nxt   = ONE_C;
            end
          end
        end
        ST_CHK_LO: begin
          if (w_s) begin
            w_state_nxt = ST_HI;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == STABLE_C) begin
            w_state_nxt = ST_LO;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = ST_LO;
          w_cnt_nxt   = '0;
        end
      endcase
      // A bounce back from CHK_LO re-enters HI but is not a new press.
      o_press_c = (w_state_nxt == ST_HI) &&
                  ((r_state == ST_LO) || (r_state == ST_CHK_HI));
    end
  end

endmodule

// File: rtl/db_event_arbiter.sv
// Debounced switch bank: per-channel debouncers, pending/overrun tracking and
// a round-robin valid/ready event port delivering one event per press.
module db_event_arbiter
  import db_event_arbiter_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned STABLE = 3,
  parameter int unsigned DIV    = 4,
  localparam int unsigned IDW   = $clog2(N)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic [N-1:0]   i_in,
  output logic [N-1:0]   o_level,
  output logic           o_ev_valid,
  input  logic           i_ev_ready,
  output logic [IDW-1:0] o_ev_id,
  output logic [N-1:0]   o_overrun
);

  localparam int unsigned TW = $clog2(DIV);

  logic [TW-1:0]  r_tick_cnt;
  logic           w_tick;
  logic [N-1:0]   w_press;
  logic [N-1:0]   r_pending;
  logic [N-1:0]   w_grant;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_cand;
  logic [IDW-1:0] w_ptr_nxt;
  logic           w_found;
  logic           w_adv;

  assign w_tick = (r_tick_cnt == TW'(DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
    end
  end

  for (genvar g = 0; g < int'(N); g++) begin : g_ch
    db_event_arbiter_channel #(
      .STABLE (STABLE)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_tick    (w_tick),
      .i_in      (i_in[g]),
      .o_level   (o_level[g]),
      .o_press_c (w_press[g])
    );
  end

  // First pending channel at or above the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_cand = IDW'((int'(r_ptr) + k) % int'(N));
      if (!w_found && r_pending[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_adv   = !o_ev_valid || i_ev_ready;
    w_grant = '0;
    if (w_adv && w_found) begin
      w_grant[w_win] = 1'b1;
    end
    w_ptr_nxt = (w_win == IDW'(N - 1)) ? '0 : w_win + IDW'(1);
  end

  // A press landing on the grant edge re-arms pending instead of overrunning.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending  <= '0;
      o_overrun  <= '0;
      o_ev_valid <= 1'b0;
      o_ev_id    <= '0;
      r_ptr      <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant) | w_press;
      o_overrun <= o_overrun | (w_press & r_pending & ~w_grant);
      if (w_adv) begin
        if (w_found) begin
          o_ev_valid <= 1'b1;
          o_ev_id    <= w_win;
          r_ptr      <= w_ptr_nxt;
        end else begin
          o_ev_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_db_event_arbiter.sv
// Scenario bench for db_event_arbiter: scoreboard of expected event ids,
// popped by a monitor on every accepted handshake.
module tb_db_event_arbiter;

  localparam int unsigned N      = 4;
  localparam int unsigned STABLE = 3;
  localparam int unsigned DIV    = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] in_r = '0;
  logic         ev_ready = 1'b0;
  logic [N-1:0] level;
  logic         ev_valid;
  logic [1:0]   ev_id;
  logic [N-1:0] overrun;

  int           checks = 0;
  int           failures = 0;
  int unsigned  edge_n = 0;
  logic [1:0]   exp_q[$];
  logic [1:0]   exp_id;

  db_event_arbiter #(.N(N), .STABLE(STABLE), .DIV(DIV)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in       (in_r),
    .o_level    (level),
    .o_ev_valid (ev_valid),
    .i_ev_ready (ev_ready),
    .o_ev_id    (ev_id),
    .o_overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got ev_id=%0d, required no event", ev_id);
      end else begin
        exp_id = exp_q.pop_front();
        if (ev_id !== exp_id) begin
          failures++;
          $display("FAIL event_id: got %0d, required %0d", ev_id, exp_id);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Edge at which a level change driven after edge e is accepted.
  function automatic int unsigned level_edge(int unsigned e);
    int unsigned first;
    first = ((e + 3 + DIV - 1) / DIV) * DIV;
    return first + (STABLE - 1) * DIV;
  endfunction

  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    in_r = '0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (level !== '0) begin failures++; $display("FAIL reset_level: got %b, required 0000", level); end
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, required 0", ev_valid); end
    checks++; if (ev_id !== 2'd0) begin failures++; $display("FAIL reset_id: got %0d, required 0", ev_id); end
    checks++; if (overrun !== '0) begin failures++; $display("FAIL reset_overrun: got %b, required 0000", overrun); end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_clean_press();
    int unsigned le;
    ev_ready = 1'b1;
    step();
    le = level_edge(edge_n);
    in_r[0] = 1'b1;
    exp_q.push_back(2'd0);
    while (edge_n < le - 1) step();
    checks++; if (level[0] !== 1'b0) begin failures++; $display("FAIL press_level_early: got %b, required 0", level[0]); end
    step();
    checks++; if (level[0] !== 1'b1) begin failures++; $display("FAIL press_level: got %b, required 1", level[0]); end
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL press_valid_latency: got %b, required 0", ev_valid); end
    step();
    checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd0) begin failures++; $display("FAIL press_event: got valid=%b id=%0d, required valid=1 id=0", ev_valid, ev_id); end
    step();
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL press_pulse: got %b, required 0", ev_valid); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL press_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_release();
    int unsigned le;
    bit saw_valid = 1'b0;
    le = level_edge(edge_n);
    in_r[0] = 1'b0;
    while (edge_n < le - 1) begin step(); saw_valid |= ev_valid; end
    checks++; if (level[0] !== 1'b1) begin failures++; $display("FAIL release_level_early: got %b, required 1", level[0]); end
    step();
    checks++; if (level[0] !== 1'b0) begin failures++; $display("FAIL release_level: got %b, required 0", level[0]); end
    repeat (3 * DIV) begin step(); saw_valid |= ev_valid; end
    checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL release_event: got valid=1, required 0"); end
  endtask

  task automatic test_bounce();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit saw_level = 1'b0;
    bit saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_r[1] = pat[i];
      repeat (DIV) begin step(); saw_level |= level[1]; saw_valid |= ev_valid; end
    end
    repeat (6 * DIV) begin step(); saw_level |= level[1]; saw_valid |= ev_valid; end
    checks++; if (saw_level !== 1'b0) begin failures++; $display("FAIL bounce_level: got 1, required 0"); end
    checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL bounce_event: got valid=1, required 0"); end
  endtask

  task automatic test_simultaneous();
    bit held = 1'b1;
    apply_reset();
    ev_ready = 1'b0;
    in_r[0] = 1'b1;
    in_r[2] = 1'b1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    for (int i = 0; i < 60 && ev_valid !== 1'b1; i++) step();
    checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd0) begin failures++; $display("FAIL simul_first: got valid=%b id=%0d, required valid=1 id=0", ev_valid, ev_id); end
    repeat (10) begin step(); if (ev_valid !== 1'b1 || ev_id !== 2'd0) held = 1'b0; end
    checks++; if (!held) begin failures++; $display("FAIL simul_hold: got id/valid changed, required held valid=1 id=0"); end
    ev_ready = 1'b1;
    step();
    checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd2) begin failures++; $display("FAIL simul_second: got valid=%b id=%0d, required valid=1 id=2", ev_valid, ev_id); end
    step();
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL simul_idle: got %b, required 0", ev_valid); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL simul_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    ev_ready = 1'b0;
    in_r[1] = 1'b1;
    exp_q.push_back(2'd1);
    for (int i = 0; i < 60 && ev_valid !== 1'b1; i++) step();
    checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd1) begin failures++; $display("FAIL ovr_block: got valid=%b id=%0d, required valid=1 id=1", ev_valid, ev_id); end
    in_r[3] = 1'b1;
    exp_q.push_back(2'd3);
    for (int i = 0; i < 60 && level[3] !== 1'b1; i++) step();
    in_r[3] = 1'b0;
    for (int i = 0; i < 60 && level[3] !== 1'b0; i++) step();
    checks++; if (overrun !== 4'b0000 || ev_id !== 2'd1) begin failures++; $display("FAIL ovr_mid: got overrun=%b id=%0d, required overrun=0000 id=1", overrun, ev_id); end
    in_r[3] = 1'b1;
    for (int i = 0; i < 60 && level[3] !== 1'b1; i++) step();
    checks++; if (overrun !== 4'b1000) begin failures++; $display("FAIL ovr_flag: got %b, required 1000", overrun); end
    ev_ready = 1'b1;
    repeat (6) step();
    checks++; if (ev_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL ovr_drain: got valid=%b left=%0d, required valid=0 left=0", ev_valid, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit saw_valid = 1'b0;
    in_r = '0;
    for (int i = 0; i < 80 && level !== '0; i++) step();
    ev_ready = 1'b0;
    in_r[2] = 1'b1;
    exp_q.push_back(2'd2);
    for (int i = 0; i < 60 && ev_valid !== 1'b1; i++) step();
    checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd2 || level[2] !== 1'b1) begin failures++; $display("FAIL rstmid_pre: got valid=%b id=%0d lvl=%b, required valid=1 id=2 lvl=1", ev_valid, ev_id, level[2]); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ev_valid !== 1'b0 || ev_id !== 2'd0) begin failures++; $display("FAIL rstmid_event: got valid=%b id=%0d, required valid=0 id=0", ev_valid, ev_id); end
    checks++; if (level !== '0 || overrun !== '0) begin failures++; $display("FAIL rstmid_state: got level=%b overrun=%b, required 0000 0000", level, overrun); end
    in_r = '0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    ev_ready = 1'b1;
    repeat (10 * DIV) begin step(); saw_valid |= ev_valid; end
    checks++; if (saw_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale: got valid=1, required 0"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
